// File: rtl/pong_pkg.sv
// Shared pong constants: FSM states, goal thresholds, screen width.
// Used by game_ctrl, the ball block and pixel_gen.
package pong_pkg;

    localparam int unsigned SCREEN_W       = 640;
    localparam int unsigned LEFT_GOAL_DEF  = 0;
    localparam int unsigned RIGHT_GOAL_DEF = 632;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE_WAIT,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } game_state_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v < lim) ? v + 4'd1 : v;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with synchronous active-low reset; a level
// already high when reset releases is not reported until it drops.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic in_q, in_d;
    logic arm_q, arm_d;

    always_comb begin
        in_d  = in;
        arm_d = arm_q | ~in;
        rise  = in & ~in_q & arm_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_q  <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            in_q  <= in_d;
            arm_q <= arm_d;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer: start, serve delay, goal detection, scoring
// and game-over, all outputs registered.
module game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned LEFT_GOAL_X  = LEFT_GOAL_DEF,
    parameter int unsigned RIGHT_GOAL_X = RIGHT_GOAL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic [9:0] ball_x,
    input  logic       start,
    output logic       ball_enable,
    output logic       ball_recenter,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0] WIN4  = 4'(WIN_SCORE);
    localparam logic [8:0] SF9   = 9'(SERVE_FRAMES);
    localparam logic [9:0] LEFT  = 10'(LEFT_GOAL_X);
    localparam logic [9:0] RIGHT = 10'(RIGHT_GOAL_X);

    game_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        p2_pt_q, p2_pt_d;
    logic        en_q, en_d;
    logic        rc_q, rc_d;
    logic        dir_q, dir_d;
    logic [3:0]  s1_q, s1_d;
    logic [3:0]  s2_q, s2_d;
    logic        over_q, over_d;
    logic        win_q, win_d;
    logic        start_rise;
    logic [3:0]  new_score;

    edge_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .in    (start),
        .rise  (start_rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p2_pt_d   = p2_pt_q;
        en_d      = 1'b0;
        rc_d      = 1'b0;
        dir_d     = dir_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        over_d    = over_q;
        win_d     = win_q;
        new_score = p2_pt_q ? sat_inc(s2_q, WIN4) : sat_inc(s1_q, WIN4);

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    s1_d    = 4'd0;
                    s2_d    = 4'd0;
                    dir_d   = 1'b0;
                    rc_d    = 1'b1;
                    over_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_SERVE_WAIT;
                end
            end
            ST_SERVE_WAIT: begin
                if (refresh_tick) begin
                    if ({1'b0, cnt_q} + 9'd1 == SF9) begin
                        cnt_d   = 8'd0;
                        en_d    = 1'b1;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                en_d = 1'b1;
                if (refresh_tick) begin
                    // Left goal is checked first so it wins a tie.
                    if (ball_x <= LEFT) begin
                        p2_pt_d = 1'b1;
                        en_d    = 1'b0;
                        state_d = ST_POINT;
                    end else if (ball_x >= RIGHT) begin
                        p2_pt_d = 1'b0;
                        en_d    = 1'b0;
                        state_d = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                rc_d  = 1'b1;
                dir_d = ~p2_pt_q;
                if (p2_pt_q) s2_d = new_score;
                else         s1_d = new_score;
                if (new_score == WIN4) begin
                    over_d  = 1'b1;
                    win_d   = p2_pt_q;
                    state_d = ST_OVER;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = ST_SERVE_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            p2_pt_q <= 1'b0;
            en_q    <= 1'b0;
            rc_q    <= 1'b0;
            dir_q   <= 1'b0;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p2_pt_q <= p2_pt_d;
            en_q    <= en_d;
            rc_q    <= rc_d;
            dir_q   <= dir_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    assign ball_enable   = en_q;
    assign ball_recenter = rc_q;
    assign serve_dir     = dir_q;
    assign score1        = s1_q;
    assign score2        = s2_q;
    assign game_over     = over_q;
    assign winner        = win_q;

endmodule
